// File: rtl/dram_blk_pkg.sv
// Shared types and constants for the DES block sequencer in front of the 64x8 dual-port DRAM.
// Byte 0 of a block is the MSB of the 64-bit word.
package dram_blk_pkg;
    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 8;
    localparam int BLK_BYTES = 8;
    localparam int NUM_BLKS  = 8;
    localparam int BLK_IDX_W = 3;
    localparam int BLK_W     = BLK_BYTES * DATA_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        RESP  = 3'd4
    } state_t;

    function automatic logic [DATA_W-1:0] blk_byte(input logic [BLK_W-1:0] w, input logic [2:0] k);
        return w[63 - 8*k -: 8];
    endfunction

    function automatic logic [BLK_W-1:0] put_byte(input logic [BLK_W-1:0] w, input logic [2:0] k,
                                                  input logic [DATA_W-1:0] b);
        logic [BLK_W-1:0] r;
        r = w;
        r[63 - 8*k -: 8] = b;
        return r;
    endfunction
endpackage

// File: rtl/dram_block_ctrl_if.sv
// Block request/response bus between a DES-side client (master) and the DRAM block sequencer (slave).
interface dram_block_ctrl_if;
    import dram_blk_pkg::*;

    // A transfer happens on a rising edge where valid and ready are both high; valid-side
    // signals must stay stable while valid is high and ready is low.
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_wr;
    logic [BLK_IDX_W-1:0] req_blk;
    logic [BLK_W-1:0]     req_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [BLK_W-1:0]     rsp_rdata;

    modport master (
        output req_valid, req_wr, req_blk, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_wr, req_blk, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/dram_block_ctrl.sv
// Moves 64-bit blocks into/out of the dual-port DRAM, two bytes per beat (even byte on port 0,
// odd byte on port 1). All outputs are registered; reads capture one beat behind the address.
module dram_block_ctrl
    import dram_blk_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    dram_block_ctrl_if.slave     bus,
    output logic                 mem_en,
    output logic                 mem_wr0,
    output logic                 mem_wr1,
    output logic [ADDR_W-1:0]    mem_add0,
    output logic [ADDR_W-1:0]    mem_add1,
    output logic [DATA_W-1:0]    mem_data0_in,
    output logic [DATA_W-1:0]    mem_data1_in,
    input  logic [DATA_W-1:0]    mem_data0_out,
    input  logic [DATA_W-1:0]    mem_data1_out,
    output state_t               dbg_state
);

    state_t               state_q, state_d;
    logic [1:0]           beat_q, beat_d;
    logic [BLK_IDX_W-1:0] blk_q, blk_d;
    logic [BLK_W-1:0]     wdata_q, wdata_d;
    logic [BLK_W-1:0]     rdata_q, rdata_d;
    logic                 req_ready_q, req_ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 mem_en_q, mem_en_d;
    logic                 mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]    add0_q, add0_d, add1_q, add1_d;
    logic [DATA_W-1:0]    wd0_q, wd0_d, wd1_q, wd1_d;
    logic [2:0]           rd_base;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        blk_d   = blk_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        // Data arriving now belongs to the previous beat's address.
        rd_base = {beat_q - 2'd1, 1'b0};

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    blk_d   = bus.req_blk;
                    wdata_d = bus.req_wdata;
                    beat_d  = 2'd0;
                    state_d = bus.req_wr ? WRITE : READ;
                end
            end
            WRITE: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) state_d = IDLE;
            end
            READ: begin
                if (beat_q != 2'd0) begin
                    rdata_d = put_byte(put_byte(rdata_q, rd_base, mem_data0_out),
                                       rd_base + 3'd1, mem_data1_out);
                end
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) state_d = DRAIN;
            end
            DRAIN: begin
                rdata_d = put_byte(put_byte(rdata_q, 3'd6, mem_data0_out), 3'd7, mem_data1_out);
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are precomputed from the next state so they line up with the beat they serve.
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        mem_en_d    = (state_d == WRITE) || (state_d == READ);
        mem_wr_d    = (state_d != WRITE);
        add0_d      = mem_en_d ? {blk_d, beat_d, 1'b0} : '0;
        add1_d      = mem_en_d ? {blk_d, beat_d, 1'b1} : '0;
        wd0_d       = (state_d == WRITE) ? blk_byte(wdata_d, {beat_d, 1'b0}) : '0;
        wd1_d       = (state_d == WRITE) ? blk_byte(wdata_d, {beat_d, 1'b1}) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= 2'd0;
            blk_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b1;
            add0_q      <= '0;
            add1_q      <= '0;
            wd0_q       <= '0;
            wd1_q       <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            blk_q       <= blk_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            add0_q      <= add0_d;
            add1_q      <= add1_d;
            wd0_q       <= wd0_d;
            wd1_q       <= wd1_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign mem_en        = mem_en_q;
    assign mem_wr0       = mem_wr_q;
    assign mem_wr1       = mem_wr_q;
    assign mem_add0      = add0_q;
    assign mem_add1      = add1_q;
    assign mem_data0_in  = wd0_q;
    assign mem_data1_in  = wd1_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_dram_block_ctrl.sv
// Bench for dram_block_ctrl: a behavioural DRAM, a block-level reference memory and an
// expected-response queue, exercised by one task per scenario.
module tb_dram_block_ctrl;
    import dram_blk_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_en, mem_wr0, mem_wr1;
    logic [5:0]  mem_add0, mem_add1;
    logic [7:0]  mem_data0_in, mem_data1_in;
    logic [7:0]  mem_data0_out, mem_data1_out;
    state_t      dbg_state;

    logic [7:0]  dram [0:63];
    logic [63:0] ref_blk [0:7];
    logic [63:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    dram_block_ctrl_if bus ();

    dram_block_ctrl dut (
        .clk(clk), .rst(rst), .bus(bus),
        .mem_en(mem_en), .mem_wr0(mem_wr0), .mem_wr1(mem_wr1),
        .mem_add0(mem_add0), .mem_add1(mem_add1),
        .mem_data0_in(mem_data0_in), .mem_data1_in(mem_data1_in),
        .mem_data0_out(mem_data0_out), .mem_data1_out(mem_data1_out),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // dual-port DRAM with registered read data; disabled cycles clear the outputs
    always @(posedge clk) begin
        if (mem_en) begin
            if (!mem_wr0) dram[mem_add0] <= mem_data0_in;
            if (!mem_wr1) dram[mem_add1] <= mem_data1_in;
            mem_data0_out <= dram[mem_add0];
            mem_data1_out <= dram[mem_add1];
        end else begin
            mem_data0_out <= 8'h00;
            mem_data1_out <= 8'h00;
        end
    end

    function automatic logic [63:0] dram_word(input int b);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[63-8*k -: 8] = dram[b*8+k];
        return r;
    endfunction

    // driver: present a request and return just after the accepting edge
    task automatic do_req(input bit wr, input logic [2:0] blk, input logic [63:0] wd, input string name);
        int w;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_blk   = blk;
        bus.req_wdata = wd;
        w = 0;
        while (!bus.req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (w >= 50) begin bad++; $display("FAIL %s accept: timed out, req_ready got 0 want 1", name); end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'($urandom_range(0, 1));
        bus.req_blk   = 3'($urandom_range(0, 7));
        bus.req_wdata = {$urandom, $urandom};
    endtask

    task automatic do_write(input logic [2:0] blk, input logic [63:0] wd, input string name);
        int edges;
        do_req(1'b1, blk, wd, name);
        ref_blk[blk] = wd;
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!bus.req_ready && edges < 20);
        total++;
        if (edges !== 4) begin bad++; $display("FAIL %s wr_ready_lat: got %0d want 4", name, edges); end
        total++;
        if (dram_word(blk) !== ref_blk[blk]) begin
            bad++; $display("FAIL %s dram_blk%0d: got %h want %h", name, blk, dram_word(blk), ref_blk[blk]);
        end
    endtask

    task automatic do_read(input logic [2:0] blk, input string name);
        int edges;
        logic [63:0] exp;
        do_req(1'b0, blk, 64'h0, name);
        exp_q.push_back(ref_blk[blk]);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!bus.rsp_valid && edges < 20);
        total++;
        if (edges !== 5) begin bad++; $display("FAIL %s rd_lat: got %0d want 5", name, edges); end
        exp = exp_q.pop_front();
        total++;
        if (bus.rsp_rdata !== exp) begin bad++; $display("FAIL %s rdata: got %h want %h", name, bus.rsp_rdata, exp); end
        @(posedge clk);
        #1;
        total++;
        if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL %s rsp_drop: got %b want 0", name, bus.rsp_valid); end
    endtask

    task automatic check_reset_outputs(input string name);
        total++;
        if ({bus.req_ready, bus.rsp_valid, mem_en, mem_wr0, mem_wr1} !== 5'b00011) begin
            bad++; $display("FAIL %s ctrl: got %b want 00011", name, {bus.req_ready, bus.rsp_valid, mem_en, mem_wr0, mem_wr1});
        end
        total++;
        if ({mem_add0, mem_add1, mem_data0_in, mem_data1_in} !== 28'h0) begin
            bad++; $display("FAIL %s bus: got %h want 0", name, {mem_add0, mem_add1, mem_data0_in, mem_data1_in});
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_blk = 3'd0; bus.req_wdata = 64'h0;
        bus.rsp_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        total++;
        if (bus.rsp_rdata !== 64'h0) begin bad++; $display("FAIL reset rdata: got %h want 0", bus.rsp_rdata); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL reset ready_early: got %b want 0", bus.req_ready); end
        @(posedge clk);
        #1;
        total++;
        if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset ready_rise: got %b want 1", bus.req_ready); end
        total++;
        if (mem_en !== 1'b0 || dbg_state !== IDLE) begin
            bad++; $display("FAIL reset idle: got en=%b st=%0d want en=0 st=0", mem_en, dbg_state);
        end
    endtask

    task automatic test_write_read();
        do_write(3'd2, 64'h0123_4567_89AB_CDEF, "wr_blk2");
        total++;
        if ({dram[16], dram[17], dram[22], dram[23]} !== 32'h0123_CDEF) begin
            bad++; $display("FAIL wr_blk2 bytes: got %h want 0123cdef", {dram[16], dram[17], dram[22], dram[23]});
        end
        do_read(3'd2, "rd_blk2");
    endtask

    task automatic test_sweep();
        for (int b = 0; b < 8; b++) do_write(3'(b), 64'hB0B0_B0B0_B0B0_B0B0 + 64'(b), "sweep_wr");
        total++;
        if (dram[0] !== 8'hB0 || dram[63] !== 8'hB7) begin
            bad++; $display("FAIL sweep bounds: got %h %h want b0 b7", dram[0], dram[63]);
        end
        for (int b = 7; b >= 0; b--) do_read(3'(b), "sweep_rd");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 1) do_write(3'($urandom_range(0, 7)), {$urandom, $urandom}, "rand_wr");
            else do_read(3'($urandom_range(0, 7)), "rand_rd");
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp, nd;
        int w;
        bus.rsp_ready = 1'b0;
        do_req(1'b0, 3'd3, 64'h0, "bp");
        exp_q.push_back(ref_blk[3]);
        exp = exp_q.pop_front();
        w = 0;
        while (!bus.rsp_valid && w < 20) begin @(negedge clk); w++; end
        nd = {$urandom, $urandom};
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_blk = 3'd6; bus.req_wdata = nd;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp || bus.req_ready !== 1'b0) begin
                bad++; $display("FAIL bp hold%0d: got v=%b rd=%h rdy=%b want v=1 rd=%h rdy=0",
                                i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, exp);
            end
        end
        total++;
        if (dram_word(6) !== ref_blk[6]) begin bad++; $display("FAIL bp no_accept: got %h want %h", dram_word(6), ref_blk[6]); end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            bad++; $display("FAIL bp release: got v=%b rdy=%b want v=0 rdy=1", bus.rsp_valid, bus.req_ready);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        ref_blk[6] = nd;
        w = 0;
        while (!bus.req_ready && w < 20) begin @(negedge clk); w++; end
        total++;
        if (dram_word(6) !== nd) begin bad++; $display("FAIL bp late_wr: got %h want %h", dram_word(6), nd); end
    endtask

    task automatic test_reset_mid_write();
        logic [63:0] old, nd;
        old = ref_blk[4];
        nd = {$urandom, $urandom};
        do_req(1'b1, 3'd4, nd, "midrst");
        @(posedge clk);
        @(posedge clk);
        #2;
        total++;
        if (dbg_state !== WRITE || mem_add0 !== 6'd36 || mem_add1 !== 6'd37) begin
            bad++; $display("FAIL midrst beat2: got st=%0d a0=%0d a1=%0d want st=1 a0=36 a1=37", dbg_state, mem_add0, mem_add1);
        end
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst_async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ref_blk[4] = {nd[63:32], old[31:0]};
        total++;
        if (dram_word(4) !== ref_blk[4]) begin bad++; $display("FAIL midrst dram: got %h want %h", dram_word(4), ref_blk[4]); end
        @(posedge clk);
        #1;
        total++;
        if (bus.req_ready !== 1'b1 || dbg_state !== IDLE) begin
            bad++; $display("FAIL midrst recover: got rdy=%b st=%0d want 1 0", bus.req_ready, dbg_state);
        end
        do_read(3'd4, "midrst_rd");
    endtask

    task automatic test_back_to_back();
        int last_cyc, w;
        bit last_wr, cur_wr;
        logic [63:0] d, exp;
        bus.rsp_ready = 1'b1;
        last_wr = 1'b0;
        last_cyc = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cur_wr = (i % 2 == 0);
            d = {$urandom, $urandom};
            bus.req_wr = cur_wr; bus.req_blk = 3'd5; bus.req_wdata = d;
            w = 0;
            while (!bus.req_ready && w < 40) begin @(negedge clk); w++; end
            total++;
            if (w >= 40 || dbg_state !== IDLE) begin bad++; $display("FAIL b2b accept%0d: got st=%0d want 0", i, dbg_state); end
            @(posedge clk);
            #1;
            if (i > 0 && last_wr) begin
                total++;
                if (cyc - last_cyc !== 5) begin bad++; $display("FAIL b2b wr_gap%0d: got %0d want 5", i, cyc - last_cyc); end
            end
            last_cyc = cyc;
            last_wr = cur_wr;
            if (cur_wr) ref_blk[5] = d;
            else begin
                exp_q.push_back(ref_blk[5]);
                w = 0;
                while (!bus.rsp_valid && w < 20) begin @(negedge clk); w++; end
                exp = exp_q.pop_front();
                total++;
                if (bus.rsp_rdata !== exp) begin bad++; $display("FAIL b2b rd%0d: got %h want %h", i, bus.rsp_rdata, exp); end
            end
        end
        bus.req_valid = 1'b0;
        w = 0;
        while (!bus.req_ready && w < 20) begin @(negedge clk); w++; end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_sweep();
        test_random();
        test_backpressure();
        test_reset_mid_write();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
